// File: rtl/roc_encoder_par.sv
// Rank-order-code encoder: streams pixel indices as AER addresses, brightest first,
// comparing LANES pixels per scan cycle behind an optional reset-address preamble.
module roc_encoder_par #(
   parameter int                    IMAGE_SIZE = 256,
   parameter int                    PIXEL_BITS = 8,
   parameter int                    LANES      = 4,
   parameter int                    AER_BITS   = 10,
   parameter int                    RST_EVENTS = 2,
   parameter logic [AER_BITS-1:0]   RST_ADDR   = AER_BITS'(10'h1FF),
   parameter int                    CNT_BITS   = $clog2(IMAGE_SIZE) + 1
) (
   input  logic                             CLK,
   input  logic                             RSTN,
   input  logic [IMAGE_SIZE*PIXEL_BITS-1:0] IMAGE,
   input  logic                             START,
   input  logic                             ABORT,
   input  logic [PIXEL_BITS-1:0]            MIN_INTENSITY,
   input  logic [CNT_BITS-1:0]              MAX_EVENTS,
   output logic [AER_BITS-1:0]              AER_ADDR,
   output logic                             AER_VALID,
   input  logic                             AER_READY,
   output logic                             BUSY,
   output logic                             DONE,
   output logic [CNT_BITS-1:0]              EVENT_COUNT
);

   localparam int IDX_W  = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PRE_W  = (RST_EVENTS > 0) ? $clog2(RST_EVENTS + 1) : 1;
   localparam int PRE_LAST_I = (RST_EVENTS > 0) ? RST_EVENTS - 1 : 0;

   localparam logic [PIXEL_BITS-1:0] INT_MAX   = {PIXEL_BITS{1'b1}};
   localparam logic [IDX_W-1:0]      LAST_BASE = IDX_W'(IMAGE_SIZE - LANES);
   localparam logic [IDX_W-1:0]      BASE_STEP = IDX_W'(LANES);
   localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(PRE_LAST_I);
   localparam logic [CNT_BITS-1:0]   CNT_FULL  = CNT_BITS'(IMAGE_SIZE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SCAN,
      S_EMIT,
      S_FIN
   } state_t;

   state_t                  state_q, state_d;
   logic [PIXEL_BITS-1:0]   intensity_q, intensity_d;
   logic [IDX_W-1:0]        base_q, base_d;
   logic [LANES-1:0]        mask_q, mask_d;
   logic [PRE_W-1:0]        pre_cnt_q, pre_cnt_d;
   logic [PIXEL_BITS-1:0]   min_q, min_d;
   logic [CNT_BITS-1:0]     max_q, max_d;
   logic [CNT_BITS-1:0]     evt_cnt_q, evt_cnt_d;
   logic [AER_BITS-1:0]     addr_q, addr_d;

   logic [PIXEL_BITS-1:0]   pix [IMAGE_SIZE];
   logic [LANES-1:0]        hit;
   logic                    hit_any;
   logic [LANE_W-1:0]       hit_lane;
   logic [IDX_W-1:0]        hit_idx;
   logic [CNT_BITS-1:0]     evt_inc;
   logic                    hs;

   for (genvar g = 0; g < IMAGE_SIZE; g++) begin : g_pix
      assign pix[g] = IMAGE[g*PIXEL_BITS +: PIXEL_BITS];
   end

   // Lane compare on the current group; masked lanes were already emitted.
   always_comb begin
      hit = '0;
      for (int k = 0; k < LANES; k++) begin
         hit[k] = mask_q[k] && (pix[base_q + IDX_W'(k)] == intensity_q);
      end
   end

   always_comb begin
      hit_any  = |hit;
      hit_lane = '0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (hit[k]) hit_lane = LANE_W'(k);
      end
   end

   assign hit_idx   = base_q + IDX_W'(hit_lane);
   assign evt_inc   = evt_cnt_q + 1'b1;
   assign AER_VALID = (state_q == S_PRE) || (state_q == S_EMIT);
   assign hs        = AER_VALID && AER_READY;

   always_comb begin
      state_d     = state_q;
      intensity_d = intensity_q;
      base_d      = base_q;
      mask_d      = mask_q;
      pre_cnt_d   = pre_cnt_q;
      min_d       = min_q;
      max_d       = max_q;
      evt_cnt_d   = evt_cnt_q;
      addr_d      = addr_q;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               min_d       = MIN_INTENSITY;
               max_d       = MAX_EVENTS;
               evt_cnt_d   = '0;
               intensity_d = INT_MAX;
               base_d      = '0;
               mask_d      = '1;
               pre_cnt_d   = '0;
               if (RST_EVENTS > 0) begin
                  addr_d  = RST_ADDR;
                  state_d = S_PRE;
               end else begin
                  state_d = S_SCAN;
               end
            end
         end

         S_PRE: begin
            if (hs) begin
               if (pre_cnt_q == PRE_LAST) begin
                  pre_cnt_d = '0;
                  state_d   = S_SCAN;
               end else begin
                  pre_cnt_d = pre_cnt_q + 1'b1;
               end
            end
         end

         S_SCAN: begin
            if (hit_any) begin
               addr_d           = AER_BITS'(hit_idx);
               mask_d[hit_lane] = 1'b0;
               state_d          = S_EMIT;
            end else if (base_q != LAST_BASE) begin
               base_d = base_q + BASE_STEP;
               mask_d = '1;
            end else if ((intensity_q == min_q) || (intensity_q == '0)) begin
               state_d = S_FIN;
            end else begin
               // Sweep finished at this level: restart from pixel 0 one step dimmer.
               intensity_d = intensity_q - 1'b1;
               base_d      = '0;
               mask_d      = '1;
            end
         end

         S_EMIT: begin
            if (hs) begin
               evt_cnt_d = evt_inc;
               if (((max_q != '0) && (evt_inc == max_q)) || (evt_inc == CNT_FULL)) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_SCAN;
               end
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A handshake in the abort cycle still counts; a pending event is dropped.
      if (ABORT && ((state_q == S_PRE) || (state_q == S_SCAN) || (state_q == S_EMIT))) begin
         state_d = S_FIN;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= S_IDLE;
         intensity_q <= INT_MAX;
         base_q      <= '0;
         mask_q      <= '0;
         pre_cnt_q   <= '0;
         min_q       <= '0;
         max_q       <= '0;
         evt_cnt_q   <= '0;
         addr_q      <= '0;
      end else begin
         state_q     <= state_d;
         intensity_q <= intensity_d;
         base_q      <= base_d;
         mask_q      <= mask_d;
         pre_cnt_q   <= pre_cnt_d;
         min_q       <= min_d;
         max_q       <= max_d;
         evt_cnt_q   <= evt_cnt_d;
         addr_q      <= addr_d;
      end
   end

   assign AER_ADDR    = addr_q;
   assign BUSY        = (state_q != S_IDLE);
   assign DONE        = (state_q == S_FIN);
   assign EVENT_COUNT = evt_cnt_q;

endmodule

// File: doc/roc_encoder_par.md
Name: roc_encoder_par

Overview:
Parametrised rank-order-code encoder and successor to the single-lane ROC encoder. It emits the pixel indices of an image as AER addresses, brightest first, with ties emitted in ascending index order. Each cycle it compares LANES pixels in parallel, stops at a programmable intensity floor or event budget, and drives the AER link through a valid/ready handshake. It sits between the image buffer and the AER input controller of the SNN core.

Parameters:
IMAGE_SIZE, 256, number of pixels; must be a multiple of LANES.
PIXEL_BITS, 8, bits per pixel; maximum intensity is 2**PIXEL_BITS-1.
LANES, 4, pixels compared per scan cycle; power of 2, at most IMAGE_SIZE.
AER_BITS, 10, AER address width; must be at least $clog2(IMAGE_SIZE).
RST_EVENTS, 2, number of reset-address events in the preamble; 0 is allowed.
RST_ADDR, 10'h1FF, address sent for each preamble event.
CNT_BITS, $clog2(IMAGE_SIZE)+1, width of the event counters.

Ports:
CLK  in  1  clock.
RSTN  in  1  asynchronous active-low reset.
IMAGE  in  IMAGE_SIZE*PIXEL_BITS  flat pixel bus; pixel i is at [i*PIXEL_BITS +: PIXEL_BITS]; must be held stable while BUSY.
START  in  1  starts encoding; sampled in IDLE only.
ABORT  in  1  ends the run at the next cycle boundary (inference ready).
MIN_INTENSITY  in  PIXEL_BITS  lowest intensity that is emitted; sampled at START.
MAX_EVENTS  in  CNT_BITS  pixel-event budget; 0 means unlimited; sampled at START.
AER_ADDR  out  AER_BITS  event address.
AER_VALID  out  1  event available.
AER_READY  in  1  downstream accepts the event.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  one-cycle pulse when a run ends.
EVENT_COUNT  out  CNT_BITS  pixel events accepted in the current or last run.

Behaviour:
- Reset values: state IDLE, AER_ADDR 0, AER_VALID 0, BUSY 0, DONE 0, EVENT_COUNT 0, all internal counters 0, intensity at maximum.
- States: IDLE, PRE, SCAN, EMIT, FIN.
- IDLE:
  - On START, latch MIN_INTENSITY and MAX_EVENTS, clear EVENT_COUNT, set intensity to maximum, base to 0, lane mask to all-ones.
  - Go to PRE if RST_EVENTS>0, otherwise go to SCAN.
- PRE:
  - AER_ADDR=RST_ADDR, AER_VALID=1.
  - Each handshake (VALID&READY) counts one preamble event.
  - After RST_EVENTS handshakes, go to SCAN.
  - Preamble events do not count in EVENT_COUNT.
- SCAN, one cycle per step:
  - hit[k] = (IMAGE[base+k]==intensity) & mask[k].
  - If any hit, take the lowest k: register AER_ADDR=base+k (zero-extended), clear mask[k], go to EMIT.
  - If no hit and base+LANES<IMAGE_SIZE: base += LANES, mask all-ones.
  - If no hit and base+LANES wraps to 0:
    - if intensity==MIN_INTENSITY or intensity==0, go to FIN;
    - otherwise intensity -= 1, base=0, mask all-ones.
  - There is no underflow below 0.
- EMIT:
  - AER_VALID=1; AER_ADDR is held stable until the handshake.
  - On the handshake, EVENT_COUNT += 1.
  - Then go to FIN if EVENT_COUNT+1==MAX_EVENTS (MAX_EVENTS≠0) or EVENT_COUNT+1==IMAGE_SIZE; otherwise return to SCAN on the same group with the updated mask.
- FIN: DONE=1 for one cycle, AER_VALID=0, then go to IDLE.
- ABORT, in any non-IDLE state:
  - If an event is pending (PRE or EMIT, VALID high, no handshake this cycle), it is withdrawn and not counted.
  - A handshake in the same cycle as ABORT is counted.
  - The next state is FIN.
- Event ordering: descending intensity; ascending index within an intensity. Each pixel is emitted at most once.
- Throughput: at most one pixel event per 2 cycles. An empty group costs 1 cycle.
- Latency: START in cycle t gives AER_VALID at t+1 (PRE, or SCAN hit at t+1 giving EMIT at t+2).
- START outside IDLE is ignored. Changing MIN_INTENSITY or MAX_EVENTS mid-run has no effect.
- EVENT_COUNT holds its value after DONE until the next START.
- Asynchronous reset mid-run returns all state to the reset values immediately. No DONE is generated.

Test Plan:
1. IMAGE_SIZE=8, LANES=4, RST_EVENTS=2, image {3,255,7,255,0,9,255,1}, MIN=0, MAX=0, READY=1 -> addresses 1FF,1FF,1,3,6,5,2,0,7,4; EVENT_COUNT=8; DONE pulses once.
2. Same image, MIN=7 -> addresses 1FF,1FF,1,3,6,5,2; EVENT_COUNT=5; pixels with values below 7 are never sent.
3. Same image, MAX_EVENTS=2 -> addresses 1FF,1FF,1,3 then DONE; EVENT_COUNT=2.
4. READY toggled 0/1 every 3 cycles -> AER_ADDR stable while VALID&!READY; sequence identical to scenario 1; no event lost or duplicated.
5. ABORT asserted while EMIT holds address 6 with READY=0 -> VALID drops, DONE next cycle, EVENT_COUNT=2. Reassert START -> full sequence restarts with the preamble.
6. RSTN asserted low during SCAN -> outputs return to reset values asynchronously. All-zero image with MIN=0 -> only 0..7 emitted, after 255 intensity sweeps.
